// File: rtl/alu_sequencer.sv
// Sequences an external ALU (load A, load B, execute, settle, capture); legal op latency 5+EXEC_WAIT cycles, illegal op 1 cycle.
// One command in flight, response held until rsp_ready; `ALU_SEQ_CHAIN_EN adds cmd_chain to reuse the last rsp_data as operand A.
module alu_sequencer #(
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic       cmd_chain,
`endif
  output logic [3:0] alu_select,
  output logic       alu_select_a,
  output logic       alu_select_b,
  output logic [7:0] alu_a_data,
  output logic [7:0] alu_b_data,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_WAIT    = 3'd4,
    ST_CAPTURE = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  localparam logic [2:0] WAIT_INIT = (EXEC_WAIT == 0) ? 3'd0 : 3'(EXEC_WAIT - 1);

  state_t     state_q;
  logic [3:0] op_q;
  logic [7:0] b_q;
  logic [2:0] wait_cnt_q;
  logic [3:0] alu_select_q;
  logic       alu_select_a_q;
  logic       alu_select_b_q;
  logic [7:0] alu_a_data_q;
  logic [7:0] alu_b_data_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_data_q;
  logic       rsp_carry_q;
  logic       rsp_err_q;
  logic [7:0] op_a_d;

`ifdef ALU_SEQ_CHAIN_EN
  assign op_a_d = cmd_chain ? rsp_data_q : cmd_a;
`else
  assign op_a_d = cmd_a;
`endif

  // Gated with rst_n so that every output reads 0 while reset is held.
  assign cmd_ready    = rst_n & (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign alu_select   = alu_select_q;
  assign alu_select_a = alu_select_a_q;
  assign alu_select_b = alu_select_b_q;
  assign alu_a_data   = alu_a_data_q;
  assign alu_b_data   = alu_b_data_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_err      = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= 4'd0;
      b_q            <= 8'd0;
      wait_cnt_q     <= 3'd0;
      alu_select_q   <= 4'd0;
      alu_select_a_q <= 1'b0;
      alu_select_b_q <= 1'b0;
      alu_a_data_q   <= 8'd0;
      alu_b_data_q   <= 8'd0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= 8'd0;
      rsp_carry_q    <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      alu_select_a_q <= 1'b0;
      alu_select_b_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q <= cmd_op;
            b_q  <= cmd_b;
            if (cmd_op[3]) begin
              // Illegal opcode: answer straight away, ALU untouched.
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 8'd0;
              rsp_carry_q <= 1'b0;
              rsp_err_q   <= 1'b1;
              state_q     <= ST_RESP;
            end else begin
              rsp_err_q      <= 1'b0;
              alu_select_a_q <= 1'b1;
              alu_a_data_q   <= op_a_d;
              state_q        <= ST_LOAD_A;
            end
          end
        end
        ST_LOAD_A: begin
          alu_select_b_q <= 1'b1;
          alu_b_data_q   <= b_q;
          state_q        <= ST_LOAD_B;
        end
        ST_LOAD_B: begin
          alu_select_q <= op_q;
          state_q      <= ST_EXEC;
        end
        ST_EXEC: begin
          if (EXEC_WAIT == 0) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_cnt_q <= WAIT_INIT;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt_q == 3'd0) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        ST_CAPTURE: begin
          rsp_data_q   <= alu_result;
          rsp_carry_q  <= alu_carry;
          rsp_valid_q  <= 1'b1;
          alu_select_q <= 4'd0;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: ALU stub, cycle-level reference model with per-cycle compare, directed and random stimulus.
module tb_alu_sequencer;

  localparam int EW = 1;
  localparam int RV = 5 + EW;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
  logic       cmd_chain;
`endif
  logic [3:0] alu_select;
  logic       alu_select_a;
  logic       alu_select_b;
  logic [7:0] alu_a_data;
  logic [7:0] alu_b_data;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;

  always #5 clk = ~clk;

  alu_sequencer #(.EXEC_WAIT(EW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
`ifdef ALU_SEQ_CHAIN_EN
    .cmd_chain    (cmd_chain),
`endif
    .alu_select   (alu_select),
    .alu_select_a (alu_select_a),
    .alu_select_b (alu_select_b),
    .alu_a_data   (alu_a_data),
    .alu_b_data   (alu_b_data),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_carry    (rsp_carry),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  // Returns {carry, result}.
  function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: begin r = a - b; return {(a < b), r}; end
      4'd2: return {1'b0, a & b};
      4'd3: return {1'b0, a | b};
      4'd4: return {1'b0, a ^ b};
      4'd5: begin r = a << 1; return {a[7], r}; end
      4'd6: begin r = a >> 1; return {a[0], r}; end
      4'd7: return {1'b0, ~a};
      default: return 9'd0;
    endcase
  endfunction

  // External ALU: operand registers loaded by the strobes, combinational result.
  logic [7:0] alu_a_q = 8'd0;
  logic [7:0] alu_b_q = 8'd0;
  always @(posedge clk) begin
    if (alu_select_a) alu_a_q <= alu_a_data;
    if (alu_select_b) alu_b_q <= alu_b_data;
  end
  assign {alu_carry, alu_result} = alu_fn(alu_select, alu_a_q, alu_b_q);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: m_k counts cycles since the accepting cycle (k=0).
  bit         m_busy = 0;
  int         m_k = 0;
  bit         m_ill = 0;
  logic [3:0] m_op = 4'd0;
  logic [7:0] m_a = 8'd0, m_b = 8'd0;
  logic [8:0] m_pend = 9'd0;
  logic [7:0] m_rd = 8'd0, m_ad = 8'd0, m_bd = 8'd0;
  logic       m_rc = 1'b0, m_re = 1'b0;
  bit         e_vld;
  logic [3:0] e_sel;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_rd = 0; m_rc = 0; m_re = 0; m_ad = 0; m_bd = 0;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_strobes", {alu_select, alu_select_a, alu_select_b}, 0);
      chk("rst_alu_data", {alu_a_data, alu_b_data}, 0);
      chk("rst_rsp", {rsp_data, rsp_carry, rsp_err}, 0);
    end else begin
      if (m_busy) begin
        m_k++;
        if (!m_ill && m_k == 1)  m_ad = m_a;
        if (!m_ill && m_k == 2)  m_bd = m_b;
        if (!m_ill && m_k == RV) {m_rc, m_rd} = m_pend;
      end
      e_vld = m_busy && (m_ill || m_k >= RV);
      e_sel = (m_busy && !m_ill && m_k >= 3 && m_k < RV) ? m_op : 4'd0;
      chk("cmd_ready", cmd_ready, !m_busy);
      chk("busy", busy, m_busy);
      chk("sel_a", alu_select_a, m_busy && !m_ill && m_k == 1);
      chk("sel_b", alu_select_b, m_busy && !m_ill && m_k == 2);
      chk("alu_select", alu_select, e_sel);
      chk("alu_a_data", alu_a_data, m_ad);
      chk("alu_b_data", alu_b_data, m_bd);
      chk("rsp_valid", rsp_valid, e_vld);
      chk("rsp_data", rsp_data, m_rd);
      chk("rsp_carry", rsp_carry, m_rc);
      chk("rsp_err", rsp_err, m_re);
      if (m_busy) begin
        if (e_vld && rsp_ready) begin
          m_busy = 0;
          resp_cnt++;
        end
      end else if (cmd_valid) begin
        m_busy = 1;
        m_k    = 0;
        m_op   = cmd_op;
        m_ill  = cmd_op[3];
`ifdef ALU_SEQ_CHAIN_EN
        m_a    = cmd_chain ? m_rd : cmd_a;
`else
        m_a    = cmd_a;
`endif
        m_b    = cmd_b;
        m_pend = alu_fn(cmd_op, m_a, cmd_b);
        if (m_ill) begin
          m_rd = 8'd0; m_rc = 1'b0; m_re = 1'b1;
        end else begin
          m_re = 1'b0;
        end
      end
    end
  end

  // Issues one command from idle and records the cycle (relative to accept) of each event.
  task automatic run_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int ja, output int jb, output int jv,
                         output logic [7:0] d, output logic c, output logic e);
    ja = 0; jb = 0; jv = 0; d = 8'd0; c = 1'b0; e = 1'b0;
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (j == 1) cmd_valid = 1'b0;
      if (alu_select_a && ja == 0) ja = j;
      if (alu_select_b && jb == 0) jb = j;
      if (rsp_valid) begin
        jv = j; d = rsp_data; c = rsp_carry; e = rsp_err;
        break;
      end
    end
    if (jv == 0) chk("rsp_timeout", 0, 1);
  endtask

  int ja, jb, jv;
  logic [7:0] d;
  logic c, e;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = 8'd0; cmd_b = 8'd0; rsp_ready = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
    cmd_chain = 1'b0;
`endif
    #3 rst_n = 1'b0;
    #1;
    chk("t0_ready_in_reset", cmd_ready, 0);
    chk("t0_outputs_in_reset", {busy, rsp_valid, rsp_data, rsp_err}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("t0_ready_after_reset", cmd_ready, 1);

    // 5 + 3 with settle time of one cycle
    run_cmd(4'h0, 8'h05, 8'h03, ja, jb, jv, d, c, e);
    chk("t1_sel_a_cycle", ja, 1);
    chk("t1_sel_b_cycle", jb, 2);
    chk("t1_rsp_cycle", jv, 6);
    chk("t1_data", d, 8'h08);
    chk("t1_carry", c, 0);
    chk("t1_err", e, 0);

    run_cmd(4'h0, 8'hFF, 8'h01, ja, jb, jv, d, c, e);
    chk("t2_data", d, 8'h00);
    chk("t2_carry", c, 1);

    run_cmd(4'hA, 8'h12, 8'h34, ja, jb, jv, d, c, e);
    chk("t3_rsp_cycle", jv, 1);
    chk("t3_err", e, 1);
    chk("t3_data", d, 8'h00);
    chk("t3_no_strobes", ja + jb, 0);

    // Stalled response with a second command already waiting.
    @(posedge clk); #2;
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_op = 4'h1; cmd_a = 8'h20; cmd_b = 8'h05;
    jv = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (j == 1) cmd_valid = 1'b0;
      if (rsp_valid) begin jv = j; break; end
    end
    chk("t4_rsp_cycle", jv, 6);
    cmd_valid = 1'b1; cmd_op = 4'h2; cmd_a = 8'hF0; cmd_b = 8'h3C;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_ready", cmd_ready, 0);
      chk("t4_hold_data", rsp_data, 8'h1B);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_idle_ready", cmd_ready, 1);
    chk("t4_valid_dropped", rsp_valid, 0);
    @(posedge clk); #1;
    chk("t4_b2b_sel_a", alu_select_a, 1);
    chk("t4_b2b_a_data", alu_a_data, 8'hF0);
    cmd_valid = 1'b0;
    jv = 0;
    for (int j = 1; j <= 30; j++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin jv = j; break; end
    end
    chk("t4_b2b_rsp_cycle", jv, 5);
    chk("t4_b2b_data", rsp_data, 8'h30);

    // Reset while waiting for the ALU to settle.
    @(posedge clk); #2;
    cmd_valid = 1'b1; cmd_op = 4'h4; cmd_a = 8'h0F; cmd_b = 8'hFF;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      if (j == 1) cmd_valid = 1'b0;
    end
    chk("t5_busy_in_wait", busy, 1);
    chk("t5_select_in_wait", alu_select, 4'h4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_ctrl", {cmd_ready, busy, rsp_valid, alu_select_a, alu_select_b, alu_select}, 0);
    chk("t5_async_data", {alu_a_data, alu_b_data, rsp_data, rsp_carry, rsp_err}, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    run_cmd(4'h4, 8'h0F, 8'hFF, ja, jb, jv, d, c, e);
    chk("t5_after_rst_cycle", jv, 6);
    chk("t5_after_rst_data", d, 8'hF0);

`ifdef ALU_SEQ_CHAIN_EN
    run_cmd(4'h0, 8'h10, 8'h20, ja, jb, jv, d, c, e);
    chk("t6_first", d, 8'h30);
    cmd_chain = 1'b1;
    run_cmd(4'h0, 8'hAA, 8'h01, ja, jb, jv, d, c, e);
    chk("t6_chained", d, 8'h31);
    cmd_chain = 1'b0;
`endif

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      cmd_a     = 8'($urandom_range(0, 255));
      cmd_b     = 8'($urandom_range(0, 255));
      rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef ALU_SEQ_CHAIN_EN
      cmd_chain = ($urandom_range(0, 1) == 1);
`endif
    end
    @(posedge clk); #2;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("rand_responses_seen", (resp_cnt > 40), 1);
    chk("end_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
